signed_sar_search: RTL and testbench
====================================

# signed_sar_search

Successive-approximation search engine that recovers an unknown 16-bit two's-complement value using only greater/less/equal comparison feedback. It issues signed probe operands to an external `signed_comparator`: the hidden target is on input `A` and the probe is on input `B`. It then consumes the comparator's `g`/`l`/`e` flags to converge on the target in at most WIDTH probes. It is the driving end of the comparator interface and is used for threshold discovery and calibration loops.

## Interface
- WIDTH, 16, operand width in bits; the search takes at most WIDTH probes.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new search; sampled only in IDLE.
- probe  out  WIDTH  signed probe value; drives comparator `B`.
- probe_valid  out  1  probe is presented and awaiting a response.
- cmp_valid  in  1  comparator flags are valid for the current probe.
- cmp_g  in  1  target > probe (signed).
- cmp_l  in  1  target < probe (signed).
- cmp_e  in  1  target == probe.
- busy  out  1  search in progress (state PROBE).
- done  out  1  one-cycle pulse; result is valid.
- result  out  WIDTH  recovered target; held until the next accepted start.
- error  out  1  sticky; the flags were not one-hot at an accepted response; cleared by the next accepted start.

## Operation
- Search runs in offset-binary space: u = value XOR 0x8000, so the signed order matches the unsigned order of u.
- Registers:
  - acc[WIDTH-1:0] holds the accumulated u.
  - bit index i counts WIDTH-1 down to 0.
- trial = acc | (1<<i); probe = trial XOR (1<<(WIDTH-1)).
- State IDLE:
  - start=1 → acc=0, i=WIDTH-1, error=0, go to PROBE.
  - All other inputs are ignored.
- State PROBE:
  - probe_valid=1 and busy=1; probe is stable until accepted.
  - A response is accepted on any cycle with cmp_valid=1 while in PROBE, including the first PROBE cycle.
- Flag update on accept:
  - cmp_g=1 → acc=trial.
  - cmp_l=1 → acc unchanged (bit i stays clear).
  - cmp_e=1 → result=probe, done, go to IDLE (early exit).
- Termination: g or l with i==0 → result = updated acc XOR 0x8000, done, go to IDLE. Otherwise i decrements and the next probe is presented on the following cycle.
- Illegal flags: flags not exactly one-hot when accepted (g&l, none, etc.) → error=1, no done, result unchanged, go to IDLE.
- start asserted while in PROBE is ignored, with no restart and no queueing.
- cmp_valid asserted while in IDLE is ignored.

## Timing
- Reset (asynchronous, immediate) values:
  - state=IDLE.
  - probe=0, probe_valid=0, busy=0, done=0, result=0, error=0.
- Deasserting rst_n mid-search aborts the search with no done pulse.
- Start latency: start sampled at edge 0 → probe_valid=1 with the first probe 0x0000 in cycle 1.
- Per-step latency:
  - Response accepted at an edge → next probe visible in the following cycle.
  - With cmp_valid tied high, one probe per cycle.
- Completion latency:
  - Worst case: 16 probes (cycles 1–16); done=1 and result valid in cycle 17.
  - Early exit after k probes → done in cycle k+1.
- done is high for exactly one cycle; busy=0 and probe_valid=0 in the done cycle.
- A new start is accepted in the done cycle itself.
- probe and probe_valid are registered outputs; the flags are sampled only at edges where probe_valid=1 and cmp_valid=1.

## Test plan
- Target 0x1234, cmp_valid=1:
  - Probes in order: 0x0000(g), 0x4000(l), 0x2000(l), 0x1000(g), …
  - Probe 14 is 0x1234(e); done in cycle 15 with result=0x1234.
- Target 0x8000 (−32768), cmp_valid=1:
  - All 16 responses are l; the last probe is 0x8001.
  - done in cycle 17 with result=0x8000; error=0.
- Targets 0x0000 and 0x7FFF:
  - 0x0000: the first probe returns e; done in cycle 2 with result=0x0000.
  - 0x7FFF: 16 probes with the last returning e; done in cycle 17 with result=0x7FFF.
- Backpressure with target 0xFFFF (−1):
  - cmp_valid is delayed 3 cycles per probe; probe is held stable throughout.
  - start pulses during busy are ignored.
  - Final result=0xFFFF with exactly one done pulse.
- Illegal flags:
  - Respond g=l=1 to probe 3 → error=1, no done, busy=0 on the next cycle.
  - The next start clears error.
- Reset mid-search:
  - Drop rst_n during probe 7 → all outputs 0 immediately, with no done.
  - After release, a fresh search on target 0x0042 returns 0x0042.

Source files
------------

// File: rtl/signed_sar_search_if.sv
// Probe/response channel between the SAR search engine and a signed comparator.
// The engine drives the probe (comparator B input); the comparator returns g/l/e flags.
interface signed_sar_search_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] probe;
    logic             probe_valid;
    logic             cmp_valid;
    logic             cmp_g;
    logic             cmp_l;
    logic             cmp_e;

    modport master (
        output probe, probe_valid,
        input  cmp_valid, cmp_g, cmp_l, cmp_e
    );

    modport slave (
        input  probe, probe_valid,
        output cmp_valid, cmp_g, cmp_l, cmp_e
    );
endinterface

// File: rtl/signed_sar_search.sv
// Successive-approximation search that recovers a signed target from g/l/e comparator feedback.
// Works in offset-binary space (value ^ MSB) so the signed order matches the unsigned bit order.
module signed_sar_search #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    signed_sar_search_if.master  bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_result,
    output logic                 o_error
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_PROBE = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_error;

    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_trial;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_probe_nxt;
    logic             w_accept;
    logic             w_onehot;
    logic             w_last;

    assign w_bit       = ONE << r_idx;
    assign w_trial     = r_acc | w_bit;
    assign w_acc_nxt   = bus.cmp_g ? w_trial : r_acc;
    // Next probe is the trial for bit i-1, built on the just-updated accumulator.
    assign w_probe_nxt = (w_acc_nxt | (w_bit >> 1)) ^ MSB;
    assign w_accept    = (r_state == S_PROBE) && bus.cmp_valid;
    assign w_onehot    = ({bus.cmp_g, bus.cmp_l, bus.cmp_e} == 3'b100) ||
                         ({bus.cmp_g, bus.cmp_l, bus.cmp_e} == 3'b010) ||
                         ({bus.cmp_g, bus.cmp_l, bus.cmp_e} == 3'b001);
    assign w_last      = (r_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_idx    <= '0;
            r_probe  <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc   <= '0;
                        r_idx   <= IW'(WIDTH - 1);
                        r_error <= 1'b0;
                        r_probe <= '0;   // first trial is MSB, i.e. signed zero
                        r_state <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (w_accept) begin
                        if (!w_onehot) begin
                            r_error <= 1'b1;
                            r_probe <= '0;
                            r_state <= S_IDLE;
                        end else if (bus.cmp_e) begin
                            r_result <= r_probe;
                            r_done   <= 1'b1;
                            r_probe  <= '0;
                            r_state  <= S_IDLE;
                        end else if (w_last) begin
                            r_result <= w_acc_nxt ^ MSB;
                            r_done   <= 1'b1;
                            r_probe  <= '0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_acc   <= w_acc_nxt;
                            r_idx   <= r_idx - 1'b1;
                            r_probe <= w_probe_nxt;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.probe       = r_probe;
    assign bus.probe_valid = (r_state == S_PROBE);
    assign o_busy          = (r_state == S_PROBE);
    assign o_done          = r_done;
    assign o_result        = r_result;
    assign o_error         = r_error;
endmodule

// File: tb/tb_signed_sar_search.sv
// Bench for signed_sar_search: behavioural comparator plus an interval/latency reference model.
module tb_signed_sar_search;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_error;
    logic [15:0] o_result;
    logic [15:0] target = 16'h0000;
    logic        cv = 1'b0;
    logic        ovr = 1'b0;
    logic [15:0] probes[$];
    logic [15:0] last_res = 16'h0000;
    int          n_tests = 0;
    int          n_fail = 0;

    signed_sar_search_if #(.WIDTH(16)) bus ();

    signed_sar_search #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .bus      (bus),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result),
        .o_error  (o_error)
    );

    always #5 clk = ~clk;

    // Ideal signed comparator: A = target, B = probe; ovr forces the illegal g=l=1 response.
    assign bus.cmp_valid = cv;
    assign bus.cmp_g = ovr | ($signed(target) > $signed(bus.probe));
    assign bus.cmp_l = ovr | ($signed(target) < $signed(bus.probe));
    assign bus.cmp_e = !ovr && (target == bus.probe);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // A search of u = target^0x8000 hits e on the probe whose set bit is u's lowest set bit.
    function automatic int exp_probes(input logic [15:0] tgt);
        logic [15:0] u;
        u = tgt ^ 16'h8000;
        if (u == 16'h0000) return 16;
        for (int b = 0; b < 16; b++)
            if (u[b]) return 16 - b;
        return 16;
    endfunction

    task automatic search(input logic [15:0] tgt, input int dly, input bit spam,
                          input int bad_at, input int rst_at);
        int cyc, nacc, w, done_cyc, ndone, lo, hi, p, t, k;
        logic [15:0] held, res_at_done;
        target = tgt;
        t = int'($signed(tgt));
        lo = -32768; hi = 32767;
        probes.delete();
        held = '0; res_at_done = '0;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        cyc = 1; nacc = 0; w = 0; done_cyc = 0; ndone = 0;
        chk("first_probe_valid", {31'd0, bus.probe_valid}, 32'd1);
        chk("first_probe", {16'd0, bus.probe}, 32'h0);
        chk("error_cleared_by_start", {31'd0, o_error}, 32'd0);
        while (cyc < 300) begin
            if (bus.probe_valid) begin
                if (w > 0) chk("probe_stable", {16'd0, bus.probe}, {16'd0, held});
                else begin
                    held = bus.probe;
                    probes.push_back(held);
                end
                if (rst_at != 0 && nacc == rst_at - 1 && w == 0) begin
                    cv = 1'b0; i_start = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    chk("rst_probe", {16'd0, bus.probe}, 32'h0);
                    chk("rst_outs", {28'd0, bus.probe_valid, o_busy, o_done, o_error}, 32'h0);
                    chk("rst_result", {16'd0, o_result}, 32'h0);
                    @(negedge clk) rst_n = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        chk("no_done_after_abort", {30'd0, o_done, o_busy}, 32'h0);
                    end
                    last_res = 16'h0000;
                    return;
                end
                if (w >= dly) begin
                    cv = 1'b1;
                    nacc++;
                    w = 0;
                    ovr = (nacc == bad_at);
                    p = int'($signed(held));
                    chk("probe_in_interval", {31'd0, (p >= lo) && (p <= hi)}, 32'd1);
                    if (!ovr) begin
                        if (p < t) lo = p + 1;
                        else if (p > t) hi = p - 1;
                    end
                end else begin
                    cv = 1'b0;
                    w++;
                end
                i_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                cv = 1'b0; ovr = 1'b0; i_start = 1'b0;
                if (o_done) begin
                    ndone++;
                    if (done_cyc == 0) begin
                        done_cyc = cyc;
                        res_at_done = o_result;
                        chk("busy_low_in_done", {31'd0, o_busy}, 32'd0);
                    end
                end else if (done_cyc != 0) break;
                else if (bad_at != 0 && nacc >= bad_at) break;
            end
            @(negedge clk);
            cyc++;
        end
        cv = 1'b0; ovr = 1'b0; i_start = 1'b0;
        if (bad_at != 0) begin
            chk("bad_error_set", {31'd0, o_error}, 32'd1);
            chk("bad_no_done", ndone, 0);
            chk("bad_busy_low", {31'd0, o_busy}, 32'd0);
            chk("bad_result_kept", {16'd0, o_result}, {16'd0, last_res});
        end else begin
            k = exp_probes(tgt);
            chk("done_pulses", ndone, 1);
            chk("result", {16'd0, res_at_done}, {16'd0, tgt});
            chk("error_clear", {31'd0, o_error}, 32'd0);
            chk("probe_count", nacc, k);
            chk("done_cycle", done_cyc, 1 + k * (dly + 1));
            last_res = tgt;
        end
    endtask

    initial begin
        logic [15:0] rt;
        #1;
        chk("reset_probe", {16'd0, bus.probe}, 32'h0);
        chk("reset_outs", {28'd0, bus.probe_valid, o_busy, o_done, o_error}, 32'h0);
        chk("reset_result", {16'd0, o_result}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Responses while idle must be ignored.
        cv = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_cmp_ignored", {30'd0, o_busy, o_done}, 32'h0);
        cv = 1'b0;

        search(16'h1234, 0, 1'b0, 0, 0);
        chk("p1234_n", probes.size(), 14);
        if (probes.size() >= 14) begin
            chk("p1234_0", {16'd0, probes[0]}, 32'h0000);
            chk("p1234_1", {16'd0, probes[1]}, 32'h4000);
            chk("p1234_2", {16'd0, probes[2]}, 32'h2000);
            chk("p1234_3", {16'd0, probes[3]}, 32'h1000);
            chk("p1234_13", {16'd0, probes[13]}, 32'h1234);
        end

        search(16'h8000, 0, 1'b0, 0, 0);
        chk("p8000_n", probes.size(), 16);
        if (probes.size() == 16) chk("p8000_last", {16'd0, probes[15]}, 32'h8001);

        search(16'h0000, 0, 1'b0, 0, 0);
        search(16'h7FFF, 0, 1'b0, 0, 0);
        search(16'hFFFF, 3, 1'b1, 0, 0);

        search(16'h5555, 0, 1'b0, 3, 0);
        search(16'h0042, 0, 1'b0, 0, 0);

        search(16'h1111, 0, 1'b0, 0, 7);
        search(16'h0042, 0, 1'b0, 0, 0);

        for (int n = 0; n < 12; n++) begin
            rt = 16'($urandom);
            search(rt, (n < 6) ? 0 : int'($urandom_range(0, 2)), n[0], 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
